// File: rtl/hazard_stall_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard/stall controller.
package hazard_stall_ctrl_pkg;

  typedef enum logic {
    RUN  = 1'b0,
    WAIT = 1'b1
  } state_e;

  localparam int unsigned REG_W        = 5;
  localparam logic [4:0]  REG_ZERO     = 5'd0;
  localparam int unsigned MAX_WAIT_DEF = 15;
  localparam int unsigned STAT_W       = 32;

endpackage

// File: rtl/hazard_stall_ctrl_stall_stats_cnt.sv
// 32-bit saturating event counter with increment enable.
module stall_stats_cnt
  import hazard_stall_ctrl_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              inc,
  output logic [STAT_W-1:0] cnt
);

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      cnt <= '0;
    end else if (inc && (cnt != {STAT_W{1'b1}})) begin
      cnt <= cnt + STAT_W'(1);
    end
  end

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Hold/bubble/flush generation for the 5-stage pipeline plus memory-wait timeout FSM.
// Optional stall/flush statistics counters are built when STALL_STATS_EN is defined.
module hazard_stall_ctrl
  import hazard_stall_ctrl_pkg::*;
#(
  parameter int unsigned MAX_WAIT = MAX_WAIT_DEF,
  parameter int unsigned CNT_W    = 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              IDEX_MemRead_i,
  input  logic [REG_W-1:0]  IDEX_RTaddr_i,
  input  logic [REG_W-1:0]  IFID_RSaddr_i,
  input  logic [REG_W-1:0]  IFID_RTaddr_i,
  input  logic              Branch_taken_i,
  input  logic              mem_req_i,
  input  logic              mem_ack_i,
  output logic              PC_hold_o,
  output logic              IFID_hold_o,
  output logic              IFID_flush_o,
  output logic              IDEX_hold_o,
  output logic              IDEX_bubble_o,
  output logic              EXMEM_hold_o,
  output logic              MEMWB_bubble_o,
  output logic              err_o,
  output logic [STAT_W-1:0] stall_cnt_o,
  output logic [STAT_W-1:0] flush_cnt_o
);

  logic lu;
  logic ms;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   wait_cnt_q, wait_cnt_d;
  logic               err_d;

  assign lu = IDEX_MemRead_i && (IDEX_RTaddr_i != REG_ZERO) &&
              ((IDEX_RTaddr_i == IFID_RSaddr_i) || (IDEX_RTaddr_i == IFID_RTaddr_i));
  assign ms = mem_req_i && !mem_ack_i;

  // Priority: memory wait masks load-use, load-use masks branch flush.
  always_comb begin
    PC_hold_o      = 1'b0;
    IFID_hold_o    = 1'b0;
    IFID_flush_o   = 1'b0;
    IDEX_hold_o    = 1'b0;
    IDEX_bubble_o  = 1'b0;
    EXMEM_hold_o   = 1'b0;
    MEMWB_bubble_o = 1'b0;
    if (ms) begin
      PC_hold_o      = 1'b1;
      IFID_hold_o    = 1'b1;
      IDEX_hold_o    = 1'b1;
      EXMEM_hold_o   = 1'b1;
      MEMWB_bubble_o = 1'b1;
    end else if (lu) begin
      PC_hold_o     = 1'b1;
      IFID_hold_o   = 1'b1;
      IDEX_bubble_o = 1'b1;
    end else if (Branch_taken_i) begin
      IFID_flush_o = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q    <= RUN;
      wait_cnt_q <= '0;
      err_o      <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      err_o      <= err_d;
    end
  end

  // Wait tracking; timeout flag is sticky until reset.
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    err_d      = err_o;
    case (state_q)
      RUN: begin
        if (ms) begin
          state_d    = WAIT;
          wait_cnt_d = CNT_W'(1);
        end
      end
      WAIT: begin
        if (mem_ack_i) begin
          state_d    = RUN;
          wait_cnt_d = '0;
        end else begin
          if (wait_cnt_q >= CNT_W'(MAX_WAIT)) begin
            err_d = 1'b1;
          end
          if (wait_cnt_q != {CNT_W{1'b1}}) begin
            wait_cnt_d = wait_cnt_q + CNT_W'(1);
          end
        end
      end
      default: begin
        state_d    = RUN;
        wait_cnt_d = '0;
      end
    endcase
  end

`ifdef STALL_STATS_EN
  logic hold_any;

  assign hold_any = PC_hold_o || IFID_hold_o || IDEX_hold_o || EXMEM_hold_o;

  stall_stats_cnt u_stall_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .inc   (hold_any),
    .cnt   (stall_cnt_o)
  );

  stall_stats_cnt u_flush_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .inc   (IFID_flush_o),
    .cnt   (flush_cnt_o)
  );
`else
  assign stall_cnt_o = '0;
  assign flush_cnt_o = '0;
`endif

endmodule

// File: doc/hazard_stall_ctrl.md
# hazard_stall_ctrl

Pipeline hazard and stall controller for the 5-stage CPU; it generates the hold, bubble and flush controls consumed by the PC, IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers. Three sources are handled:

- load-use data hazards between ID/EX and IF/ID;
- taken-branch flushes resolved in ID;
- multi-cycle data-memory waits via a req/ack handshake.

A small FSM with a wait counter tracks memory waits and flags timeouts.

## Interface
Parameters:
- MAX_WAIT, 15: memory wait cycles tolerated before err_o sets (1..255).
- CNT_W, 8: wait counter width; must hold MAX_WAIT.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  reset. One clock; reset is asynchronous and active-low.
- IDEX_MemRead_i  in  1  ID/EX stage holds a load.
- IDEX_RTaddr_i  in  5  load destination register in ID/EX.
- IFID_RSaddr_i  in  5  rs of instruction in IF/ID.
- IFID_RTaddr_i  in  5  rt of instruction in IF/ID.
- Branch_taken_i  in  1  branch resolved taken in ID this cycle.
- mem_req_i  in  1  EX/MEM issues data-memory read/write.
- mem_ack_i  in  1  data memory completes access this cycle.
- PC_hold_o  out  1  PC keeps value.
- IFID_hold_o  out  1  IF/ID keeps value.
- IFID_flush_o  out  1  IF/ID loads a NOP.
- IDEX_hold_o  out  1  ID/EX keeps value.
- IDEX_bubble_o  out  1  ID/EX loads zero WB/M/EX control bits.
- EXMEM_hold_o  out  1  EX/MEM keeps value.
- MEMWB_bubble_o  out  1  MEM/WB loads zero WB control bits.
- err_o  out  1  sticky memory-timeout flag.
- stall_cnt_o  out  32  stall cycle count (see Configuration).
- flush_cnt_o  out  32  flush event count (see Configuration).

## Operation
Combinational conditions:
- lu = IDEX_MemRead_i & (IDEX_RTaddr_i != 0) & (IDEX_RTaddr_i == IFID_RSaddr_i | IDEX_RTaddr_i == IFID_RTaddr_i).
- ms = mem_req_i & ~mem_ack_i.

Conditions are evaluated in priority order; the first true one sets the outputs:
- ms: PC_hold_o, IFID_hold_o, IDEX_hold_o, EXMEM_hold_o and MEMWB_bubble_o are 1. All other controls are 0, so lu and branch are masked.
- lu: PC_hold_o, IFID_hold_o and IDEX_bubble_o are 1. IFID_flush_o is 0 even if Branch_taken_i is 1, because branch operands are not yet valid.
- Branch_taken_i: IFID_flush_o is 1.
- Otherwise all controls are 0.

FSM states:
- RUN: on ms, go to WAIT; wait_cnt loads 1.
- WAIT: on mem_ack_i, go to RUN; wait_cnt clears. Otherwise wait_cnt increments, saturating at its maximum.
- The WAIT→RUN transition completes on the cycle ack is sampled. Hold outputs are already deasserted combinationally in that cycle.

Timeout:
- When the state is WAIT and wait_cnt reaches MAX_WAIT with ack still 0, err_o sets on the next edge.
- err_o is cleared only by reset. The pipeline keeps waiting; there is no forced release.

## Timing
- All hold, bubble and flush outputs are combinational from the inputs, with zero latency, and are valid the same cycle.
- err_o and the counters are registered: one cycle of latency.
- A load-use stall lasts exactly 1 cycle. The bubble clears IDEX_MemRead_i next cycle, so lu drops without needing state.
- A load-use hazard that arises during a memory wait is re-evaluated on the first cycle after ack.
- Single-cycle memory (req and ack high in the same cycle) produces no stall and no state change.
- Reset values: state RUN, wait_cnt 0, err_o 0, counters 0.
- While rst_i is low, the combinational outputs still follow the inputs.
- Reset asserted during WAIT returns the FSM to RUN immediately.

## Configuration
STALL_STATS_EN:
- Defined: stall_cnt_o counts every cycle with any hold asserted. flush_cnt_o counts every cycle with IFID_flush_o=1. Both are 32-bit, saturate at 0xFFFFFFFF and reset to 0.
- Undefined: both ports are driven constant 0 and no counter flops exist. The port list is unchanged.

## Structure
- Shared package holds:
  - FSM state encoding: RUN=1'b0, WAIT=1'b1.
  - Register-zero constant 5'd0.
  - Default MAX_WAIT.
- One sub-module, stall_stats_cnt: a 32-bit saturating counter with increment enable. It is instantiated twice, only under STALL_STATS_EN.

## Test plan
- IDEX_MemRead_i=1, IDEX_RTaddr_i=5, IFID_RSaddr_i=5 -> PC_hold_o, IFID_hold_o and IDEX_bubble_o are 1 for one cycle; with IDEX_RTaddr_i=0 -> no stall.
- Branch_taken_i=1 with no hazard -> IFID_flush_o=1 for one cycle. Same cycle plus a load-use on rt=7 -> flush 0, stall 1.
- mem_req_i=1, mem_ack_i=0 for 3 cycles, then ack=1 -> all holds plus MEMWB_bubble_o for 3 cycles, released on the ack cycle; err_o stays 0.
- MAX_WAIT=4, ack withheld for 10 cycles -> err_o rises 1 cycle after wait_cnt reaches 4, stays 1 after ack, and clears only on rst_i low.
- Memory wait plus simultaneous load-use and branch -> only the memory holds are asserted; after ack, the load-use stall appears for 1 cycle.
- With STALL_STATS_EN: 3-cycle memory wait + 1 load-use + 2 flushes -> stall_cnt_o=4, flush_cnt_o=2. Without the macro -> both read 0.
